// File: rtl/mdu_sequencer_pkg.sv
// Shared encodings for the multiply/divide sequencer: op codes, ALU control
// codes, shift codes and FSM states.
package mdu_sequencer_pkg;

   localparam int unsigned MDU_XLEN  = 32;
   localparam int unsigned MDU_CNT_W = 5;

   typedef enum logic [1:0] {
      MDU_MUL  = 2'b00,
      MDU_DIVU = 2'b01,
      MDU_REMU = 2'b10,
      MDU_RSVD = 2'b11
   } mdu_op_e;

   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;

   localparam logic [1:0] SH_NONE = 2'b00;
   localparam logic [1:0] SHL     = 2'b11;
   localparam logic [1:0] SHR     = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ITER = 2'b01,
      ST_DONE = 2'b10
   } mdu_state_e;

endpackage

// File: rtl/mdu_step_regs.sv
// Datapath registers for shift-add multiply / restoring divide (acc|R, M|Q, P|D)
// plus ALU operand formation and borrow/ge. MDU_EARLY_OUT_EN enables multiply early-out.
module mdu_step_regs
   import mdu_sequencer_pkg::*;
#(
   parameter int unsigned XLEN = MDU_XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load_i,
   input  logic            step_i,
   input  logic            is_div_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic [XLEN-1:0] alu_result_i,
   output logic [XLEN-1:0] alu_a_o,
   output logic [XLEN-1:0] alu_b_o,
   output logic [XLEN-1:0] x_nxt_o,
   output logic [XLEN-1:0] y_nxt_o,
   output logic            early_o
);

   logic [XLEN-1:0] x_q, x_d;
   logic [XLEN-1:0] y_q, y_d;
   logic [XLEN-1:0] z_q, z_d;
   logic [XLEN:0]   s_c;
   logic            borrow_c;
   logic            ge_c;

   // Partial remainder shifted left with the next dividend bit
   assign s_c      = {x_q, y_q[XLEN-1]};
   assign borrow_c = (s_c[XLEN-1] ^ z_q[XLEN-1]) ? z_q[XLEN-1] : alu_result_i[XLEN-1];
   assign ge_c     = s_c[XLEN] | ~borrow_c;

   always_comb begin
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      alu_a_o = x_q;
      alu_b_o = z_q[0] ? y_q : '0;
      if (is_div_i) begin
         alu_a_o = s_c[XLEN-1:0];
         alu_b_o = z_q;
      end
      if (load_i) begin
         x_d = '0;
         y_d = a_i;
         z_d = b_i;
      end else if (step_i) begin
         if (is_div_i) begin
            x_d = ge_c ? alu_result_i : s_c[XLEN-1:0];
            y_d = {y_q[XLEN-2:0], ge_c};
         end else begin
            x_d = alu_result_i;
            y_d = y_q << 1;
            z_d = z_q >> 1;
         end
      end
   end

   assign x_nxt_o = x_d;
   assign y_nxt_o = y_d;

`ifdef MDU_EARLY_OUT_EN
   // Multiplier exhausted once the bit being consumed is the last one set
   assign early_o = ~is_div_i & ~(|z_q[XLEN-1:1]);
`else
   assign early_o = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q <= '0;
         y_q <= '0;
         z_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
         z_q <= z_d;
      end
   end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle unsigned MUL/DIVU/REMU controller that borrows the shared add/sub ALU.
// Optional build macro MDU_EARLY_OUT_EN shortens multiplies by small multipliers.
module mdu_sequencer
   import mdu_sequencer_pkg::*;
#(
   parameter int unsigned XLEN  = MDU_XLEN,
   parameter int unsigned CNT_W = MDU_CNT_W
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic [1:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o,
   output logic            div0_o,
   output logic            alu_own_o,
   output logic [3:0]      alu_ctrl_o,
   output logic [1:0]      alu_shift_o,
   output logic            alu_src_o,
   output logic [XLEN-1:0] alu_a_o,
   output logic [XLEN-1:0] alu_b_o,
   input  logic [XLEN-1:0] alu_result_i
);

   mdu_state_e      state_q, state_d;
   mdu_op_e         op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            div0_q, div0_d;
   logic            own_q, own_d;
   logic [XLEN-1:0] result_q, result_d;

   logic            load_c;
   logic            step_c;
   logic            is_div_c;
   logic            early_c;
   logic [XLEN-1:0] step_a_c;
   logic [XLEN-1:0] step_b_c;
   logic [XLEN-1:0] x_nxt_c;
   logic [XLEN-1:0] y_nxt_c;

   assign is_div_c = (op_q == MDU_DIVU) || (op_q == MDU_REMU);

   mdu_step_regs #(.XLEN(XLEN)) u_step (
      .clk          (clk),
      .rst          (rst),
      .load_i       (load_c),
      .step_i       (step_c),
      .is_div_i     (is_div_c),
      .a_i          (a_i),
      .b_i          (b_i),
      .alu_result_i (alu_result_i),
      .alu_a_o      (step_a_c),
      .alu_b_o      (step_b_c),
      .x_nxt_o      (x_nxt_c),
      .y_nxt_o      (y_nxt_c),
      .early_o      (early_c)
   );

   // Next-state, counter and result selection
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      div0_d   = div0_q;
      result_d = result_q;
      load_c   = 1'b0;
      step_c   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               load_c = 1'b1;
               op_d   = mdu_op_e'(op_i);
               busy_d = 1'b1;
               cnt_d  = '0;
               if (op_i == MDU_RSVD) begin
                  state_d  = ST_DONE;
                  done_d   = 1'b1;
                  div0_d   = 1'b0;
                  result_d = '0;
               end else if ((op_i != MDU_MUL) && (b_i == '0)) begin
                  state_d  = ST_DONE;
                  done_d   = 1'b1;
                  div0_d   = 1'b1;
                  result_d = (op_i == MDU_DIVU) ? '1 : a_i;
               end else begin
                  state_d = ST_ITER;
               end
            end
         end
         ST_ITER: begin
            step_c = 1'b1;
            cnt_d  = cnt_q + CNT_W'(1);
            if ((cnt_q == CNT_W'(XLEN - 1)) || early_c) begin
               state_d  = ST_DONE;
               done_d   = 1'b1;
               div0_d   = 1'b0;
               result_d = (op_q == MDU_DIVU) ? y_nxt_c : x_nxt_c;
            end
         end
         ST_DONE: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      own_d = (state_d == ST_ITER);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         op_q     <= MDU_MUL;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         div0_q   <= 1'b0;
         own_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         div0_q   <= div0_d;
         own_q    <= own_d;
         result_q <= result_d;
      end
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign div0_o      = div0_q;
   assign result_o    = result_q;
   assign alu_own_o   = own_q;
   assign alu_shift_o = SH_NONE;
   assign alu_src_o   = 1'b1;
   // ALU operands are released to the main datapath whenever not iterating
   assign alu_ctrl_o  = (own_q && is_div_c) ? ALU_SUB : ALU_ADD;
   assign alu_a_o     = own_q ? step_a_c : '0;
   assign alu_b_o     = own_q ? step_b_c : '0;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer with a behavioural add/sub ALU that
// registers its result on the falling edge. Honours MDU_EARLY_OUT_EN.
module tb_mdu_sequencer;

   localparam int unsigned XLEN = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            start_i;
   logic [1:0]      op_i;
   logic [XLEN-1:0] a_i;
   logic [XLEN-1:0] b_i;
   logic            busy_o;
   logic            done_o;
   logic [XLEN-1:0] result_o;
   logic            div0_o;
   logic            alu_own_o;
   logic [3:0]      alu_ctrl_o;
   logic [1:0]      alu_shift_o;
   logic            alu_src_o;
   logic [XLEN-1:0] alu_a_o;
   logic [XLEN-1:0] alu_b_o;
   logic [XLEN-1:0] alu_result;

   int total = 0;
   int bad   = 0;

   mdu_sequencer dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start_i),
      .op_i         (op_i),
      .a_i          (a_i),
      .b_i          (b_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .result_o     (result_o),
      .div0_o       (div0_o),
      .alu_own_o    (alu_own_o),
      .alu_ctrl_o   (alu_ctrl_o),
      .alu_shift_o  (alu_shift_o),
      .alu_src_o    (alu_src_o),
      .alu_a_o      (alu_a_o),
      .alu_b_o      (alu_b_o),
      .alu_result_i (alu_result)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      alu_result <= (alu_ctrl_o == 4'b0110) ? (alu_a_o - alu_b_o) : (alu_a_o + alu_b_o);
   end

   function automatic logic [31:0] model_res(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      logic [63:0] p;
      case (op)
         2'd0: begin p = 64'(a) * 64'(b); return p[31:0]; end
         2'd1: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         2'd2: return (b == 0) ? a : a % b;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic model_dz(input logic [1:0] op, input logic [31:0] b);
      return ((op == 2'd1) || (op == 2'd2)) && (b == 0);
   endfunction

   // Edges after the accepting edge until done_o is seen; 0 = very next cycle
   function automatic int model_lat(input logic [1:0] op, input logic [31:0] b);
      int hi;
      if (op == 2'd3 || (op != 2'd0 && b == 0)) return 0;
`ifdef MDU_EARLY_OUT_EN
      if (op == 2'd0) begin
         hi = 0;
         for (int i = 0; i < 32; i++) if (b[i]) hi = i + 1;
         return (hi < 1) ? 1 : hi;
      end
`endif
      hi = 32;
      return hi;
   endfunction

   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic dz, output int lat,
                         output logic iter_ok, output logic timeout);
      logic [3:0] ectrl;
      ectrl = (op == 2'd0) ? 4'b0010 : 4'b0110;
      @(posedge clk); #1;
      op_i = op; a_i = a; b_i = b; start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      op_i = 2'($urandom); a_i = $urandom; b_i = $urandom;
      lat = 0; iter_ok = 1'b1;
      while (done_o !== 1'b1 && lat < 100) begin
         if (alu_own_o !== 1'b1 || alu_ctrl_o !== ectrl || busy_o !== 1'b1) iter_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      timeout = (done_o !== 1'b1);
      res = result_o;
      dz  = div0_o;
   endtask

   task automatic test_reset;
      rst = 1'b1; start_i = 1'b0; op_i = 2'd0; a_i = '0; b_i = '0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_o); end
      total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done_o); end
      total++; if (alu_own_o !== 1'b0) begin bad++; $display("FAIL reset_own got=%b want=0", alu_own_o); end
      total++; if (div0_o !== 1'b0) begin bad++; $display("FAIL reset_div0 got=%b want=0", div0_o); end
      total++; if (result_o !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", result_o); end
      total++; if (alu_ctrl_o !== 4'b0010 || alu_a_o !== 32'h0 || alu_b_o !== 32'h0)
         begin bad++; $display("FAIL reset_alu got ctrl=%b a=%h b=%h want 0010/0/0", alu_ctrl_o, alu_a_o, alu_b_o); end
      total++; if (alu_shift_o !== 2'b00 || alu_src_o !== 1'b1)
         begin bad++; $display("FAIL reset_ties got shift=%b src=%b want 00/1", alu_shift_o, alu_src_o); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic check_op(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b);
      logic [31:0] res, er;
      logic dz, ok, to;
      int lat, el;
      run_op(op, a, b, res, dz, lat, ok, to);
      er = model_res(op, a, b);
      el = model_lat(op, b);
      total++; if (to) begin bad++; $display("FAIL %s_timeout no done_o within 100 cycles", name); end
      total++; if (res !== er) begin bad++; $display("FAIL %s_result got=%h want=%h (a=%h b=%h)", name, res, er, a, b); end
      total++; if (dz !== model_dz(op, b)) begin bad++; $display("FAIL %s_div0 got=%b want=%b", name, dz, model_dz(op, b)); end
      total++; if (lat != el) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", name, lat, el); end
      total++; if (!ok) begin bad++; $display("FAIL %s_iter own/ctrl/busy wrong during iteration", name); end
      total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL %s_busy_at_done got=%b want=1", name, busy_o); end
      @(posedge clk); #1;
      total++; if (done_o !== 1'b0 || busy_o !== 1'b0 || result_o !== er)
         begin bad++; $display("FAIL %s_hold got done=%b busy=%b res=%h want 0/0/%h", name, done_o, busy_o, result_o, er); end
   endtask

   task automatic test_directed;
      check_op("mul_7x6",   2'd0, 32'd7,         32'd6);
      check_op("mul_max_2", 2'd0, 32'hFFFF_FFFF, 32'd2);
      check_op("mul_3x5",   2'd0, 32'd3,         32'd5);
      check_op("mul_by0",   2'd0, 32'h1234_5678, 32'd0);
      check_op("divu_100_7",2'd1, 32'd100,       32'd7);
      check_op("remu_100_7",2'd2, 32'd100,       32'd7);
      check_op("divu_big",  2'd1, 32'h8000_0000, 32'hFFFF_FFFF);
      check_op("remu_big",  2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      check_op("divu_by0",  2'd1, 32'd5,         32'd0);
      check_op("remu_by0",  2'd2, 32'd5,         32'd0);
      check_op("reserved",  2'd3, 32'd9,         32'd3);
   endtask

   task automatic test_random;
      logic [1:0]  op;
      logic [31:0] a, b;
      for (int n = 0; n < 40; n++) begin
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         case ($urandom_range(0, 3))
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 15));
            default: b = $urandom;
         endcase
         check_op("rand", op, a, b);
      end
   endtask

   task automatic test_ignore_start;
      int n;
      logic [31:0] er;
      er = model_res(2'd0, 32'd1234567, 32'h8000_0003);
      @(posedge clk); #1;
      op_i = 2'd0; a_i = 32'd1234567; b_i = 32'h8000_0003; start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      n = 0;
      while (done_o !== 1'b1 && n < 100) begin
         if (n == 10) begin op_i = 2'd1; a_i = 32'd77; b_i = 32'd0; start_i = 1'b1; end
         else start_i = 1'b0;
         @(posedge clk); #1;
         n++;
      end
      start_i = 1'b0;
      total++; if (n != 32 || result_o !== er || div0_o !== 1'b0)
         begin bad++; $display("FAIL ignore_start got lat=%0d res=%h div0=%b want 32/%h/0", n, result_o, div0_o, er); end
   endtask

   task automatic test_reset_mid;
      @(posedge clk); #1;
      op_i = 2'd0; a_i = 32'd99; b_i = 32'hF000_0001; start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      repeat (15) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      total++; if (busy_o !== 1'b0 || alu_own_o !== 1'b0 || alu_a_o !== 32'h0)
         begin bad++; $display("FAIL reset_mid got busy=%b own=%b alu_a=%h want 0/0/0", busy_o, alu_own_o, alu_a_o); end
      total++; if (result_o !== 32'h0 || done_o !== 1'b0)
         begin bad++; $display("FAIL reset_mid_out got res=%h done=%b want 0/0", result_o, done_o); end
      @(negedge clk);
      rst = 1'b0;
      check_op("after_reset", 2'd0, 32'd123, 32'd45);
   endtask

   task automatic test_back_to_back;
      int n;
      logic [31:0] er;
      er = model_res(2'd0, 32'hDEAD_BEEF, 32'h9000_0011);
      @(posedge clk); #1;
      op_i = 2'd0; a_i = 32'hDEAD_BEEF; b_i = 32'h9000_0011; start_i = 1'b1;
      @(posedge clk); #1;
      op_i = 2'd1; a_i = 32'd9; b_i = 32'd0;
      n = 0;
      while (done_o !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
      total++; if (n != model_lat(2'd0, 32'h9000_0011) || result_o !== er)
         begin bad++; $display("FAIL b2b_first got lat=%0d res=%h want %0d/%h", n, result_o, model_lat(2'd0, 32'h9000_0011), er); end
      @(posedge clk); #1;
      total++; if (done_o !== 1'b0 || busy_o !== 1'b0)
         begin bad++; $display("FAIL b2b_gap got done=%b busy=%b want 0/0", done_o, busy_o); end
      @(posedge clk); #1;
      start_i = 1'b0;
      total++; if (done_o !== 1'b1 || result_o !== 32'hFFFF_FFFF || div0_o !== 1'b1)
         begin bad++; $display("FAIL b2b_second got done=%b res=%h div0=%b want 1/ffffffff/1", done_o, result_o, div0_o); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multi-cycle unsigned multiply/divide controller that reuses the existing 32-bit ALU (add/sub only) instead of dedicated arithmetic.
- Borrows the ALU from the main datapath while busy; the top level multiplexes ALU inputs on alu_own_o.
- Runs one ALU operation per clock. The ALU result is registered on the falling edge, and this block samples it on the next rising edge.

Parameters:
- XLEN, 32, operand/result width; must match ALU width.
- CNT_W, 5, iteration counter width, equal to log2(XLEN).

Ports:
- clk  in  1  system clock, rising-edge logic.
- rst  in  1  asynchronous reset, active-high.
- start_i  in  1  request pulse; sampled only in IDLE.
- op_i  in  2  00 MUL (low word), 01 DIVU (quotient), 10 REMU (remainder), 11 reserved.
- a_i  in  XLEN  multiplicand / dividend; captured on start.
- b_i  in  XLEN  multiplier / divisor; captured on start.
- busy_o  out  1  high from start acceptance until done_o.
- done_o  out  1  one-cycle completion pulse.
- result_o  out  XLEN  result; held from done_o until next accepted start.
- div0_o  out  1  divide-by-zero flag; valid with done_o, held like result_o.
- alu_own_o  out  1  high while the sequencer drives the ALU (state ITER).
- alu_ctrl_o  out  4  ALU control code: 0010 add, 0110 sub.
- alu_shift_o  out  2  tied 00.
- alu_src_o  out  1  tied 1, selecting the register operand.
- alu_a_o  out  XLEN  ALU operand 1.
- alu_b_o  out  XLEN  ALU operand 2.
- alu_result_i  in  XLEN  registered ALU result.

Behaviour:
- Reset (async, rst=1): state=IDLE. busy_o, done_o, alu_own_o, div0_o = 0. result_o = 0. All internal registers = 0. Reset mid-operation aborts immediately and releases the ALU.
- States: IDLE -> ITER -> DONE -> IDLE; IDLE -> DONE directly for div0/reserved.
- IDLE:
  - start_i=1 captures op_i, a_i, b_i and sets busy_o, cnt=0.
  - Enters DONE if op is DIVU/REMU with b_i==0, or if op_i==11; otherwise enters ITER.
- ITER: issues one ALU op per cycle. At each rising edge it captures alu_result_i for the op issued in the previous cycle. cnt increments; after cnt==XLEN-1 is captured, state goes to DONE.
- MUL step (registers: acc, mcand M, multiplier P):
  - Issue add with alu_a_o=acc and alu_b_o = P[0] ? M : 0.
  - Capture: acc<=alu_result_i, M<=M<<1, P<=P>>1.
  - Result = acc; the upper product word is discarded.
- DIV step (registers: rem R, quotient Q initialised to dividend, divisor D):
  - Form 33-bit s={R,Q[31]}. Issue sub with alu_a_o=s[31:0], alu_b_o=D.
  - borrow = (s[31]^D[31]) ? D[31] : alu_result_i[31].
  - ge = s[32] | ~borrow.
  - Capture: R <= ge ? alu_result_i : s[31:0]; Q <= {Q[30:0], ge}.
- DONE: lasts one cycle. done_o=1, busy_o drops at the next edge, state returns to IDLE.
  - result_o: acc for MUL, Q for DIVU, R for REMU.
  - Divide by zero: result_o is all ones for DIVU and the dividend for REMU; div0_o=1.
  - Reserved op: result_o=0, div0_o=0.
- Latency: done_o is high exactly XLEN cycles after the start edge for normal ops, and 1 cycle after for div0/reserved.
- start_i while busy is ignored and does not queue. Start in the same cycle done_o is high is ignored; the next start is accepted in IDLE.
- While alu_own_o=0: alu_a_o/alu_b_o = 0, alu_ctrl_o = 0010.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined: in MUL, if the captured P>>1 is zero, go to DONE after that capture. Latency becomes max(1, index of highest set bit of b + 1) cycles. Multiply by 0 finishes in 1 iteration.
- Not defined: fixed XLEN-iteration latency for all non-trivial ops.
- Divide latency is unaffected either way.

Decomposition:
- Shared package holds:
  - Op encodings: MDU_MUL, MDU_DIVU, MDU_REMU.
  - ALU control constants: ALU_ADD=0010, ALU_SUB=0110, ALU_AND=0000, ALU_OR=0001.
  - Shift codes: SHL=11, SHR=10.
  - State enum.
- One natural sub-module, mdu_step_regs, holds the acc/R, M/Q, P/D datapath registers and the borrow/ge logic. The FSM and counter stay in the top.

Test Plan:
- MUL a=7, b=6 -> done_o exactly 32 cycles after start, result_o=42, div0_o=0; alu_ctrl_o=0010 and alu_own_o=1 throughout ITER.
- MUL a=0xFFFFFFFF, b=2 -> result_o=0xFFFFFFFE. With MDU_EARLY_OUT_EN, MUL 3*5 -> result 15, done_o 3 cycles after start.
- DIVU 100/7 -> result 14; REMU 100/7 -> 2; DIVU 0x80000000/0xFFFFFFFF -> 0; REMU same operands -> 0x80000000.
- DIVU 5/0 -> done_o 1 cycle after start, result 0xFFFFFFFF, div0_o=1; REMU 5/0 -> result 5, div0_o=1.
- start_i pulsed again at cycle 10 of a MUL -> ignored and the original result is unchanged; rst asserted at cycle 15 -> busy_o and alu_own_o drop immediately, and the next start runs cleanly.
